exec_seq: RTL

Execute-stage sequencer that sits directly upstream of the 64-bit adder `alu`, in the same pipeline stage. It accepts one operation per request over a valid/ready handshake and drives the ALU's `inA_i`, `inB_i` and `cflag_i`. It captures `out_o` and the flags, and presents a registered result and flags over a second valid/ready handshake. Left shifts run serially through the ALU by doubling (A+A); right shifts run serially in a local one-bit shifter.

---
 rtl/exec_seq_pkg.sv | 31 +++
 rtl/exec_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execute-stage sequencer: op codes, FSM states,
// flag bit positions and a small op-class helper.
package exec_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/exec_seq.sv
// Execute-stage sequencer feeding an external combinational 64-bit adder.
// Left shifts iterate through the adder (A+A); right shifts iterate locally.
//
// state  | meaning
// S_IDLE | ready for a request; operands load on valid_i
// S_EXEC | shift steps while count != 0, capture result when count == 0
// S_DONE | result held until rready_i
module exec_seq
  import exec_seq_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         rvalid_o,
  input  logic         rready_i,
  output logic [W-1:0] result_o,
  output logic [3:0]   flags_o,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic         alu_c_o,
  input  logic [W-1:0] alu_out_i,
  input  logic         alu_c_i,
  input  logic         alu_v_i,
  input  logic         alu_z_i
);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         c_q, c_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic [W-1:0] cap_res;
  logic [3:0]   cap_flg;
  logic [3:0]   alu_flg;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i)       state_d = S_EXEC;
      S_EXEC:  if (cnt_q == 6'd0) state_d = S_DONE;
      S_DONE:  if (rready_i)      state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE);
    rvalid_o = (state_q == S_DONE);
  end

  always_comb begin
    alu_flg        = '0;
    alu_flg[F_N]   = alu_out_i[W-1];
    alu_flg[F_Z]   = alu_z_i;
    alu_flg[F_C]   = alu_c_i;
    alu_flg[F_V]   = alu_v_i;
  end

  // Result and flags as they would be captured this cycle; illegal ops give 0/0.
  always_comb begin
    cap_res = '0;
    cap_flg = '0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        cap_res = alu_out_i;
        cap_flg = alu_flg;
      end
      OP_SLT: begin
        cap_res = {{(W-1){1'b0}}, alu_out_i[W-1] ^ alu_v_i};
        cap_flg = alu_flg;
      end
      OP_SLTU: begin
        cap_res = {{(W-1){1'b0}}, ~alu_c_i};
        cap_flg = alu_flg;
      end
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: begin
        if (op_q == OP_AND)      cap_res = a_q & b_q;
        else if (op_q == OP_OR)  cap_res = a_q | b_q;
        else if (op_q == OP_XOR) cap_res = a_q ^ b_q;
        else                     cap_res = a_q;
        cap_flg[F_N] = cap_res[W-1];
        cap_flg[F_Z] = ~|cap_res;
      end
      default: ;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d  = op_i;
          a_d   = a_i;
          b_d   = b_i;
          c_d   = 1'b0;
          cnt_d = is_shift(op_i) ? b_i[5:0] : 6'd0;
          case (op_i)
            OP_SUB, OP_SLT, OP_SLTU: begin
              b_d = ~b_i;
              c_d = 1'b1;
            end
            OP_SLL:         b_d = a_i;
            OP_SRL, OP_SRA: b_d = '0;
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        // A nonzero count only ever comes from a shift op.
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
          case (op_q)
            OP_SLL: begin
              a_d = alu_out_i;
              b_d = alu_out_i;
            end
            OP_SRL:  a_d = {1'b0, a_q[W-1:1]};
            OP_SRA:  a_d = {a_q[W-1], a_q[W-1:1]};
            default: ;
          endcase
        end else begin
          result_d = cap_res;
          flags_d  = cap_flg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= 6'd0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;
  assign alu_c_o  = c_q;
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule
